updi_uart_rx: RTL

Serial receiver for the UPDI single-wire link. Recovers 8-bit characters framed as start + DATA_BITS + optional parity + STOP_BITS from an oversampled `rx` line. Checks parity through the existing `parity` module and presents each character, with its error flags, on a one-entry valid/ready output register. It is the receive-side counterpart of the UPDI transmit path and feeds the UPDI command/response logic.

---
 rtl/updi_pkg.sv | 27 ++
 rtl/parity.sv | 15 +
 rtl/updi_uart_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/updi_pkg.sv
// Shared types for the UPDI receive path: FSM states, parity mode names and output bundle.
package updi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam string PARITY_NONE = "none";
    localparam string PARITY_EVEN = "even";
    localparam string PARITY_ODD  = "odd";

    localparam int MAX_DATA_BITS = 8;

    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     parity_err;
        logic                     frame_err;
        logic                     brk;
        logic                     overrun;
    } rx_char_t;

endpackage

// File: rtl/parity.sv
// Expected parity bit over a data word; constant 0 when the link runs without parity.
module parity
    import updi_pkg::*;
#(
    parameter int    BITS   = 8,
    parameter string PARITY = "even"
) (
    input  logic [BITS-1:0] data,
    output logic            par
);

    assign par = (PARITY == PARITY_NONE) ? 1'b0 :
                 (PARITY == PARITY_ODD)  ? ~^data : ^data;

endmodule

// File: rtl/updi_uart_rx.sv
// UPDI serial receiver: start/data/parity/stop framing into a one-entry valid/ready register.
// Define UPDI_UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling (decisions one cycle later).
module updi_uart_rx
    import updi_pkg::*;
#(
    parameter int    CLKS_PER_BIT = 16,
    parameter int    DATA_BITS    = 8,
    parameter string PARITY       = "even",
    parameter int    STOP_BITS    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_parity_err,
    output logic                 out_frame_err,
    output logic                 out_break,
    output logic                 out_overrun,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int  HALF    = CLKS_PER_BIT / 2;
    localparam int  CW      = $clog2(CLKS_PER_BIT);
    localparam int  IW      = $clog2(DATA_BITS + 1);
    localparam bit  HAS_PAR = (PARITY != PARITY_NONE);

`ifdef UPDI_UART_RX_MAJORITY_EN
    localparam int START_LOAD = HALF;
`else
    localparam int START_LOAD = HALF - 1;
`endif

    localparam logic [CW-1:0] START_CNT = CW'(START_LOAD);
    localparam logic [CW-1:0] BIT_CNT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    rx_state_t             state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         bit_idx;
    logic                  stop_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  par_bit;
    logic                  par_err;
    logic                  frm_err;
    rx_char_t              out_reg;
    logic                  valid_r;
    logic                  exp_par;
    logic                  bit_val;
    logic                  tick;
    logic                  frame_now;

`ifdef UPDI_UART_RX_MAJORITY_EN
    logic rx_d1, rx_d2;

    // Two-deep history so the decision at s+1 can vote over samples s-1, s, s+1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx;
            rx_d2 <= rx_d1;
        end
    end

    assign bit_val = (rx & rx_d1) | (rx & rx_d2) | (rx_d1 & rx_d2);
`else
    assign bit_val = rx;
`endif

    assign tick      = (cnt == '0);
    assign frame_now = frm_err | ~bit_val;

    parity #(
        .BITS   (DATA_BITS),
        .PARITY (PARITY)
    ) u_parity (
        .data (shreg),
        .par  (exp_par)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            out_reg  <= '0;
            valid_r  <= 1'b0;
        end else begin
            // A commit later in this block overrides the accept-side clear.
            if (valid_r && out_ready)
                valid_r <= 1'b0;

            if (state != IDLE && state != WAIT_HIGH)
                cnt <= tick ? BIT_CNT : cnt - 1'b1;

            case (state)
                IDLE: begin
                    if (!rx) begin
                        state    <= START;
                        cnt      <= START_CNT;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        par_bit  <= 1'b0;
                        par_err  <= 1'b0;
                        frm_err  <= 1'b0;
                    end
                end
                START: begin
                    if (tick)
                        state <= bit_val ? IDLE : DATA;
                end
                DATA: begin
                    if (tick) begin
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_DATA)
                            state <= HAS_PAR ? PAR : STOP;
                    end
                end
                PAR: begin
                    if (tick) begin
                        par_bit <= bit_val;
                        par_err <= (bit_val != exp_par);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_idx == LAST_STOP) begin
                            out_reg.data       <= MAX_DATA_BITS'(shreg);
                            out_reg.parity_err <= par_err;
                            out_reg.frame_err  <= frame_now;
                            out_reg.brk        <= frame_now && (shreg == '0) && !par_bit;
                            out_reg.overrun    <= valid_r && !out_ready;
                            valid_r            <= 1'b1;
                            state              <= frame_now ? WAIT_HIGH : IDLE;
                        end else begin
                            frm_err  <= frame_now;
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_data       = out_reg.data[DATA_BITS-1:0];
    assign out_parity_err = out_reg.parity_err;
    assign out_frame_err  = out_reg.frame_err;
    assign out_break      = out_reg.brk;
    assign out_overrun    = out_reg.overrun;
    assign out_valid      = valid_r;
    assign busy           = (state != IDLE);

endmodule
